// File: rtl/div_seq_if.sv
// EX-stage <-> divider handshake bundle: operands and control in, 64-bit result,
// ready and stall request out.
interface div_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for div/divu: one quotient bit per cycle,
// stalls the pipeline while busy, result = {remainder, quotient}.
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned WORK_W = 2 * DATA_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORK_W-1:0]     work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  sgn_q, sgn_d;
  logic                  neg1_q, neg1_d;
  logic                  neg2_q, neg2_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     abs1, abs2;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quot_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sgn_q     <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sgn_q     <= sgn_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    // |0x80..0| negates to itself, which is the correct unsigned magnitude
    abs1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? ('0 - bus.opdata1_i) : bus.opdata1_i;
    abs2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? ('0 - bus.opdata2_i) : bus.opdata2_i;
    diff     = work_q[WORK_W-1:DATA_W] - {1'b0, divisor_q};
    quot_fix = (sgn_q && (neg1_q ^ neg2_q)) ? ('0 - work_q[DATA_W-1:0]) : work_q[DATA_W-1:0];
    rem_fix  = (sgn_q && neg1_q) ? ('0 - work_q[WORK_W-1:DATA_W+1]) : work_q[WORK_W-1:DATA_W+1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sgn_d     = sgn_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      S_IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d   = S_ON;
            cnt_d     = '0;
            work_d    = {{(DATA_W+1){1'b0}}, abs1} << 1;
            divisor_d = abs2;
            sgn_d     = bus.signed_div_i;
            neg1_d    = bus.opdata1_i[DATA_W-1];
            neg2_d    = bus.opdata2_i[DATA_W-1];
          end
        end
      end

      // Ready comes from END's hold branch one edge later, giving the 2-edge latency
      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
      end

      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
          ready_d = 1'b0;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          state_d  = S_END;
          cnt_d    = '0;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end else begin
          if (diff[DATA_W]) begin
            work_d = work_q << 1;
          end else begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_END: begin
        if (!bus.start_i || bus.annul_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          ready_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, stall window, signed fixes, divide by zero,
// overflow, annul, mid-run reset and the start/ready handshake.
module tb_div_seq;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  div_seq_if #(.DATA_W(32)) bus ();

  div_seq #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start with operands; optionally scramble operands after the start edge.
  // n = number of edges until ready is seen (edge 0 counts as 1), stall = samples with stallreq high.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic scramble, output int n, output int stall);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    n = 0;
    stall = 0;
    do begin
      step();
      n++;
      if (bus.stallreq_o) stall++;
      if (scramble && n == 1) begin
        bus.signed_div_i = ~sgn;
        bus.opdata1_i    = 32'hDEAD_BEEF;
        bus.opdata2_i    = 32'h0000_0000;
      end
    end while (!bus.ready_o && n < 100);
  endtask

  task automatic end_div();
    bus.start_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    step(); step();
    total_cnt++;
    if (bus.ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready_o); else pass_cnt++;
    total_cnt++;
    if (bus.result_o !== 64'h0) $display("FAIL reset_result got %h want 0", bus.result_o); else pass_cnt++;
    total_cnt++;
    if (bus.stallreq_o !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.stallreq_o); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    int n, st;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, n, st);
    total_cnt++;
    if (n - 1 !== 33) $display("FAIL divu_latency got %0d want 33", n - 1); else pass_cnt++;
    total_cnt++;
    if (st !== 33) $display("FAIL divu_stall_cycles got %0d want 33", st); else pass_cnt++;
    total_cnt++;
    if (bus.stallreq_o !== 1'b0) $display("FAIL divu_stall_drop got %b want 0", bus.stallreq_o); else pass_cnt++;
    total_cnt++;
    if (bus.result_o !== {32'h2, 32'hE}) $display("FAIL divu_100_7 got %h want %h", bus.result_o, {32'h2, 32'hE}); else pass_cnt++;
    end_div();
    total_cnt++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0)
      $display("FAIL end_to_idle got ready=%b result=%h want 0/0", bus.ready_o, bus.result_o);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    int n, st;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, n, st);
    total_cnt++;
    if (bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
      $display("FAIL div_m7_2 got %h want %h", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    else pass_cnt++;
    end_div();
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, n, st);
    total_cnt++;
    if (bus.result_o !== {32'h0000_0001, 32'hFFFF_FFFD})
      $display("FAIL div_7_m2 got %h want %h", bus.result_o, {32'h0000_0001, 32'hFFFF_FFFD});
    else pass_cnt++;
    end_div();
  endtask

  task automatic test_div_zero();
    int n, st;
    run_div(1'b1, 32'd5, 32'd0, 1'b0, n, st);
    total_cnt++;
    if (n - 1 !== 2) $display("FAIL divzero_latency got %0d want 2", n - 1); else pass_cnt++;
    total_cnt++;
    if (bus.result_o !== 64'h0) $display("FAIL divzero_result got %h want 0", bus.result_o); else pass_cnt++;
    end_div();
  endtask

  task automatic test_overflow();
    int n, st;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n, st);
    total_cnt++;
    if (bus.result_o !== {32'h0, 32'h8000_0000})
      $display("FAIL div_ovf got %h want %h", bus.result_o, {32'h0, 32'h8000_0000});
    else pass_cnt++;
    end_div();
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, n, st);
    total_cnt++;
    if (bus.result_o !== {32'h0, 32'hFFFF_FFFF})
      $display("FAIL divu_max_1 got %h want %h", bus.result_o, {32'h0, 32'hFFFF_FFFF});
    else pass_cnt++;
    end_div();
  endtask

  task automatic test_annul();
    int n, st, seen;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    for (int i = 0; i < 11; i++) step();
    bus.start_i = 1'b0;
    bus.annul_i = 1'b1;
    step();
    bus.annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ready_o) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL annul_no_ready got %0d ready cycles want 0", seen); else pass_cnt++;
    run_div(1'b0, 32'd1000, 32'd10, 1'b0, n, st);
    total_cnt++;
    if (n - 1 !== 33 || bus.result_o !== {32'h0, 32'd100})
      $display("FAIL annul_restart got lat=%0d result=%h want 33/%h", n - 1, bus.result_o, {32'h0, 32'd100});
    else pass_cnt++;
    end_div();
    // start held with annul in IDLE must not launch a division
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b1;
    step(); step(); step();
    total_cnt++;
    if (bus.ready_o !== 1'b0) $display("FAIL annul_idle_ready got %b want 0", bus.ready_o); else pass_cnt++;
    run_div(1'b0, 32'd9, 32'd3, 1'b0, n, st);
    total_cnt++;
    if (n - 1 !== 33) $display("FAIL annul_idle_latency got %0d want 33", n - 1); else pass_cnt++;
    end_div();
  endtask

  task automatic test_mid_reset();
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    for (int i = 0; i < 21; i++) step();
    rst = 1'b1;
    bus.start_i = 1'b0;
    step();
    total_cnt++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0 || bus.stallreq_o !== 1'b0)
      $display("FAIL midrun_reset got ready=%b result=%h stall=%b want 0", bus.ready_o, bus.result_o, bus.stallreq_o);
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int n, st;
    run_div(1'b0, 32'd100, 32'd7, 1'b0, n, st);
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (bus.ready_o !== 1'b1 || bus.result_o !== {32'h2, 32'hE})
        $display("FAIL hold_stable got ready=%b result=%h want 1/%h", bus.ready_o, bus.result_o, {32'h2, 32'hE});
      else pass_cnt++;
    end
    end_div();
    total_cnt++;
    if (bus.ready_o !== 1'b0) $display("FAIL drop_ready got %b want 0", bus.ready_o); else pass_cnt++;
    run_div(1'b0, 32'd9, 32'd3, 1'b1, n, st);
    total_cnt++;
    if (n - 1 !== 33) $display("FAIL b2b_latency got %0d want 33", n - 1); else pass_cnt++;
    total_cnt++;
    if (bus.result_o !== {32'h0, 32'h3}) $display("FAIL b2b_9_3 got %h want %h", bus.result_o, {32'h0, 32'h3}); else pass_cnt++;
    end_div();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
